reorder_buffer: RTL and testbench

- Circular in-order reorder buffer.
- Sits directly upstream of issue_queue: dispatch allocates an entry here; the returned tail index travels with the uop into the issue queue as rob_index.
- Tracks completion reported by the ISSUE_PORTS writeback ports.
- Retires one instruction per cycle in program order, releasing the superseded physical register to the free list.

---
 rtl/reorder_buffer_pkg.sv | 20 ++
 rtl/reorder_buffer.sv | 162 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and the reorder-buffer entry layout used by dispatch, the ROB and debug logic.
// The exc field exists only when ROB_EXCEPTION_EN is defined.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE_LOG2 = 4;
  localparam int unsigned NUM_REG_LOG2  = 6;
  localparam int unsigned REG_SIZE      = 64;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [4:0]            ard;
    logic [NUM_REG_LOG2:0] prd;
    logic [NUM_REG_LOG2:0] old_prd;
`ifdef ROB_EXCEPTION_EN
    logic                  exc;
`endif
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, complete out of order, retire one per cycle.
// Optional precise-exception reporting is enabled with ROB_EXCEPTION_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_SIZE    = 16,
  parameter int unsigned ISSUE_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc_valid,
  input  logic [4:0]                         alloc_ard,
  input  logic [NUM_REG_LOG2:0]              alloc_prd,
  input  logic [NUM_REG_LOG2:0]              alloc_old_prd,
  output logic                               alloc_ready,
  output logic [ROB_SIZE_LOG2-1:0]           alloc_rob_index,
  input  logic [ISSUE_PORTS-1:0]             wb_valid,
  input  logic [ISSUE_PORTS*ROB_SIZE_LOG2-1:0] wb_rob_index,
`ifdef ROB_EXCEPTION_EN
  input  logic [ISSUE_PORTS-1:0]             wb_exc,
  output logic                               exception_valid,
  output logic [ROB_SIZE_LOG2-1:0]           exception_rob_index,
`endif
  output logic                               commit_valid,
  output logic [4:0]                         commit_ard,
  output logic [NUM_REG_LOG2:0]              commit_prd,
  output logic [NUM_REG_LOG2:0]              commit_free_prd,
  input  logic                               flush_in,
  output logic                               rob_empty,
  output logic [ROB_SIZE_LOG2:0]             rob_count
);

  localparam int unsigned PtrW = ROB_SIZE_LOG2;
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(ROB_SIZE);
  localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

  rob_entry_t             entries_q [ROB_SIZE];
  rob_entry_t             entries_d [ROB_SIZE];
  logic [PtrW-1:0]        head_q, head_d;
  logic [PtrW-1:0]        tail_q, tail_d;
  logic [PtrW:0]          count_q, count_d;
  logic [ROB_SIZE-1:0]    wb_hit;
  logic                   full;
  logic                   alloc_fire;
  logic                   flush_all;
  rob_entry_t             head_entry;

  assign head_entry = entries_q[head_q];
  assign full       = (count_q == CountFull);

`ifdef ROB_EXCEPTION_EN
  logic [ROB_SIZE-1:0] wb_hit_exc;
  logic                head_exc;

  // A done head carrying an exception blocks its commit and flushes the ROB at the next edge.
  assign head_exc            = head_entry.valid && head_entry.done && head_entry.exc;
  assign exception_valid     = head_exc && !flush_in;
  assign exception_rob_index = head_q;
  assign commit_valid        = head_entry.valid && head_entry.done && !head_entry.exc && !flush_in;
  assign flush_all           = flush_in || exception_valid;
  assign alloc_ready         = !full && !flush_in && !exception_valid;
`else
  assign commit_valid = head_entry.valid && head_entry.done && !flush_in;
  assign flush_all    = flush_in;
  assign alloc_ready  = !full && !flush_in;
`endif

  assign alloc_fire      = alloc_valid && alloc_ready;
  assign alloc_rob_index = tail_q;
  assign commit_ard      = head_entry.ard;
  assign commit_prd      = head_entry.prd;
  assign commit_free_prd = head_entry.old_prd;
  assign rob_empty       = (count_q == '0);
  assign rob_count       = count_q;

  // Completion decode; two ports hitting the same index collapse into one completion.
  always_comb begin
    wb_hit = '0;
`ifdef ROB_EXCEPTION_EN
    wb_hit_exc = '0;
`endif
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      if (wb_valid[p]) begin
        wb_hit[wb_rob_index[p*PtrW +: PtrW]] = 1'b1;
`ifdef ROB_EXCEPTION_EN
        if (wb_exc[p]) wb_hit_exc[wb_rob_index[p*PtrW +: PtrW]] = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (entries_q[i].valid && wb_hit[i]) begin
        entries_d[i].done = 1'b1;
`ifdef ROB_EXCEPTION_EN
        entries_d[i].exc  = entries_q[i].exc || wb_hit_exc[i];
`endif
      end
    end
    if (commit_valid) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].done  = 1'b0;
    end
    // Allocation overrides any stale writeback aimed at the not-yet-valid tail slot.
    if (alloc_fire) begin
      entries_d[tail_q].valid   = 1'b1;
      entries_d[tail_q].done    = 1'b0;
      entries_d[tail_q].ard     = alloc_ard;
      entries_d[tail_q].prd     = alloc_prd;
      entries_d[tail_q].old_prd = alloc_old_prd;
`ifdef ROB_EXCEPTION_EN
      entries_d[tail_q].exc     = 1'b0;
`endif
    end
    if (flush_all) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
`ifdef ROB_EXCEPTION_EN
        entries_d[i].exc   = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_all) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_valid) head_d = head_q + PtrOne;
      if (alloc_fire)   tail_d = tail_q + PtrOne;
      unique case ({alloc_fire, commit_valid})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; covers the exception path when
// ROB_EXCEPTION_EN is defined.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      alloc_valid;
  logic [4:0]                alloc_ard;
  logic [NUM_REG_LOG2:0]     alloc_prd;
  logic [NUM_REG_LOG2:0]     alloc_old_prd;
  logic                      alloc_ready;
  logic [ROB_SIZE_LOG2-1:0]  alloc_rob_index;
  logic [1:0]                wb_valid;
  logic [2*ROB_SIZE_LOG2-1:0] wb_rob_index;
  logic                      commit_valid;
  logic [4:0]                commit_ard;
  logic [NUM_REG_LOG2:0]     commit_prd;
  logic [NUM_REG_LOG2:0]     commit_free_prd;
  logic                      flush_in;
  logic                      rob_empty;
  logic [ROB_SIZE_LOG2:0]    rob_count;
`ifdef ROB_EXCEPTION_EN
  logic [1:0]                wb_exc;
  logic                      exception_valid;
  logic [ROB_SIZE_LOG2-1:0]  exception_rob_index;
`endif

  int tests = 0;
  int fails = 0;

  reorder_buffer #(
    .ROB_SIZE    (16),
    .ISSUE_PORTS (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_ard       (alloc_ard),
    .alloc_prd       (alloc_prd),
    .alloc_old_prd   (alloc_old_prd),
    .alloc_ready     (alloc_ready),
    .alloc_rob_index (alloc_rob_index),
    .wb_valid        (wb_valid),
    .wb_rob_index    (wb_rob_index),
`ifdef ROB_EXCEPTION_EN
    .wb_exc              (wb_exc),
    .exception_valid     (exception_valid),
    .exception_rob_index (exception_rob_index),
`endif
    .commit_valid    (commit_valid),
    .commit_ard      (commit_ard),
    .commit_prd      (commit_prd),
    .commit_free_prd (commit_free_prd),
    .flush_in        (flush_in),
    .rob_empty       (rob_empty),
    .rob_count       (rob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int ard, input int prd, input int old_prd);
    alloc_valid   = 1'b1;
    alloc_ard     = 5'(ard);
    alloc_prd     = 7'(prd);
    alloc_old_prd = 7'(old_prd);
  endtask

  initial begin
    rst = 1'b0; alloc_valid = 1'b0; alloc_ard = '0; alloc_prd = '0; alloc_old_prd = '0;
    wb_valid = '0; wb_rob_index = '0; flush_in = 1'b0;
`ifdef ROB_EXCEPTION_EN
    wb_exc = '0;
`endif
    #3;
    check("rst_ready", alloc_ready, 1);
    check("rst_index", alloc_rob_index, 0);
    check("rst_commit", commit_valid, 0);
    check("rst_empty", rob_empty, 1);
    check("rst_count", rob_count, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Three allocations, no writebacks
    for (int i = 0; i < 3; i++) begin
      alloc(i + 1, 33 + i, i + 1);
      #1 check("alloc_idx", alloc_rob_index, i);
      check("alloc_no_commit", commit_valid, 0);
      tick();
    end
    alloc_valid = 1'b0;
    #1 check("count3", rob_count, 3);
    check("count3_commit", commit_valid, 0);

    // Out-of-order completion 2,0,1 -> in-order commits 0,1,2
    wb_valid = 2'b10; wb_rob_index = 8'h20;
    #1 check("ooo_nc0", commit_valid, 0);
    tick();
    wb_valid = 2'b01; wb_rob_index = 8'h00;
    #1 check("ooo_nc1", commit_valid, 0);
    tick();
    wb_valid = 2'b10; wb_rob_index = 8'h10;
    #1 check("c0_valid", commit_valid, 1);
    check("c0_ard", commit_ard, 1);
    check("c0_prd", commit_prd, 33);
    check("c0_free", commit_free_prd, 1);
    tick();
    wb_valid = 2'b00;
    #1 check("c1_valid", commit_valid, 1);
    check("c1_prd", commit_prd, 34);
    check("c1_free", commit_free_prd, 2);
    tick();
    #1 check("c2_valid", commit_valid, 1);
    check("c2_free", commit_free_prd, 3);
    tick();
    #1 check("drain_empty", rob_empty, 1);
    check("drain_count", rob_count, 0);
    check("drain_commit", commit_valid, 0);

    // Dual-port write to 5, stray write to unallocated 9; head/tail now at 3
    for (int i = 3; i < 6; i++) begin
      alloc(i + 1, 37 + i, 7 + i);
      #1 check("alloc35_idx", alloc_rob_index, i);
      tick();
    end
    alloc_valid = 1'b0;
    wb_valid = 2'b11; wb_rob_index = 8'h55;
    tick();
    wb_valid = 2'b01; wb_rob_index = 8'h09;
    tick();
    wb_valid = 2'b00;
    for (int i = 6; i < 10; i++) begin
      alloc(i + 1, 37 + i, 7 + i);
      tick();
    end
    alloc_valid = 1'b0;
    #1 check("count7", rob_count, 7);
    check("count7_commit", commit_valid, 0);
    wb_valid = 2'b11; wb_rob_index = 8'h43;
    tick();
    wb_valid = 2'b00;
    #1 check("c3_prd", commit_prd, 40);
    check("c3_valid", commit_valid, 1);
    tick();
    #1 check("c4_prd", commit_prd, 41);
    check("c4_valid", commit_valid, 1);
    tick();
    #1 check("c5_dual_valid", commit_valid, 1);
    check("c5_free", commit_free_prd, 12);
    tick();
    #1 check("c6_wait", commit_valid, 0);
    wb_valid = 2'b11; wb_rob_index = 8'h76;
    tick();
    wb_valid = 2'b01; wb_rob_index = 8'h08;
    #1 check("c6_prd", commit_prd, 43);
    tick();
    wb_valid = 2'b00;
    #1 check("c7_prd", commit_prd, 44);
    tick();
    #1 check("c8_prd", commit_prd, 45);
    check("c8_valid", commit_valid, 1);
    tick();
    #1 check("e9_not_done", commit_valid, 0);
    check("e9_count", rob_count, 1);

    // Flush with 7 valid entries, head done, alloc and wb active
    for (int i = 10; i < 16; i++) begin
      alloc(i, 40 + i, i);
      if (i == 15) begin
        wb_valid = 2'b01; wb_rob_index = 8'h09;
      end
      tick();
    end
    wb_valid = 2'b11; wb_rob_index = 8'hBA; flush_in = 1'b1;
    alloc(1, 99, 1);
    #1 check("fl_commit", commit_valid, 0);
    check("fl_ready", alloc_ready, 0);
    check("fl_count_before", rob_count, 7);
    tick();
    flush_in = 1'b0; alloc_valid = 1'b0; wb_valid = 2'b00;
    #1 check("fl_count", rob_count, 0);
    check("fl_index", alloc_rob_index, 0);
    check("fl_empty", rob_empty, 1);
    check("fl_ready_after", alloc_ready, 1);

    // Fill all 16, then commit index 0 with alloc held high
    for (int i = 0; i < 16; i++) begin
      alloc(i, 64 + i, i);
      #1 check("fill_idx", alloc_rob_index, i);
      tick();
    end
    alloc(20, 99, 30);
    #1 check("full_ready", alloc_ready, 0);
    check("full_count", rob_count, 16);
    tick();
    wb_valid = 2'b01; wb_rob_index = 8'h00;
    #1 check("full_ready_wb", alloc_ready, 0);
    tick();
    wb_valid = 2'b00;
    #1 check("k_commit", commit_valid, 1);
    check("k_prd", commit_prd, 64);
    check("k_ready", alloc_ready, 0);
    tick();
    #1 check("k1_ready", alloc_ready, 1);
    check("k1_index", alloc_rob_index, 0);
    check("k1_count", rob_count, 15);
    check("k1_commit", commit_valid, 0);
    tick();
    alloc_valid = 1'b0;
    #1 check("wrap_count", rob_count, 16);
    check("wrap_index", alloc_rob_index, 1);

    // Asynchronous reset while a commit is pending
    wb_valid = 2'b01; wb_rob_index = 8'h01;
    tick();
    wb_valid = 2'b00;
    #1 check("pre_rst_commit", commit_valid, 1);
    rst = 1'b0;
    #1 check("mid_rst_commit", commit_valid, 0);
    check("mid_rst_count", rob_count, 0);
    check("mid_rst_empty", rob_empty, 1);
    tick();
    rst = 1'b1;
    tick();

`ifdef ROB_EXCEPTION_EN
    alloc(1, 20, 5);
    tick();
    alloc(2, 21, 6);
    tick();
    alloc_valid = 1'b0;
    wb_valid = 2'b11; wb_rob_index = 8'h01; wb_exc = 2'b01;
    tick();
    wb_valid = 2'b00; wb_exc = 2'b00;
    #1 check("ex_c0_valid", commit_valid, 1);
    check("ex_c0_prd", commit_prd, 20);
    check("ex_c0_exc", exception_valid, 0);
    tick();
    #1 check("ex_commit", commit_valid, 0);
    check("ex_valid", exception_valid, 1);
    check("ex_index", exception_rob_index, 1);
    tick();
    #1 check("ex_once", exception_valid, 0);
    check("ex_empty", rob_empty, 1);
    check("ex_tail", alloc_rob_index, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
